// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational fetch lookup,
// execute-stage training, mispredict detection and a saturating mispredict statistics counter.
module branch_predictor #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      PCF,
    output logic                 PredTakenF,
    output logic [XLEN-1:0]      PredTargetF,
    input  logic                 UpdateE,
    input  logic                 IsJumpE,
    input  logic [XLEN-1:0]      PCE,
    input  logic                 TakenE,
    input  logic [XLEN-1:0]      TargetE,
    input  logic                 PredTakenE,
    input  logic [XLEN-1:0]      PredTargetE,
    output logic                 MispredictE,
    output logic [CNT_WIDTH-1:0] MispredCount
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - 2 - IDX;

    logic                 r_valid  [ENTRIES];
    logic [TAGW-1:0]      r_tag    [ENTRIES];
    logic [XLEN-1:0]      r_target [ENTRIES];
    logic [1:0]           r_ctr    [ENTRIES];
    logic [CNT_WIDTH-1:0] r_cnt;

    logic [IDX-1:0]  w_fidx, w_eidx;
    logic [TAGW-1:0] w_ftag, w_etag;
    logic            w_fhit, w_ehit;

    assign w_fidx = PCF[IDX+1:2];
    assign w_ftag = PCF[XLEN-1:IDX+2];
    assign w_eidx = PCE[IDX+1:2];
    assign w_etag = PCE[XLEN-1:IDX+2];

    assign w_fhit = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
    assign w_ehit = r_valid[w_eidx] && (r_tag[w_eidx] == w_etag);

    // Lookup reads only registered state, so a same-cycle update is not bypassed.
    assign PredTakenF  = w_fhit && r_ctr[w_fidx][1];
    assign PredTargetF = PredTakenF ? r_target[w_fidx] : '0;

    assign MispredictE = UpdateE && ((PredTakenE != TakenE) ||
                                     (TakenE && (PredTargetE != TargetE)));
    assign MispredCount = r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
            r_cnt <= '0;
        end else begin
            if (MispredictE && (r_cnt != '1))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            if (UpdateE) begin
                if (w_ehit) begin
                    if (IsJumpE) begin
                        r_ctr[w_eidx]    <= 2'b11;
                        r_target[w_eidx] <= TargetE;
                    end else if (TakenE) begin
                        if (r_ctr[w_eidx] != 2'b11)
                            r_ctr[w_eidx] <= r_ctr[w_eidx] + 2'd1;
                        r_target[w_eidx] <= TargetE;
                    end else if (r_ctr[w_eidx] != 2'b00) begin
                        r_ctr[w_eidx] <= r_ctr[w_eidx] - 2'd1;
                    end
                end else if (TakenE) begin
                    // Taken miss evicts whatever alias occupies the slot.
                    r_valid[w_eidx]  <= 1'b1;
                    r_tag[w_eidx]    <= w_etag;
                    r_target[w_eidx] <= TargetE;
                    r_ctr[w_eidx]    <= IsJumpE ? 2'b11 : 2'b10;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver pushes model expectations, negedge monitor compares.
// A second instance with a 2-bit statistics counter shares the stimulus to exercise saturation.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF, PCE, TargetE, PredTargetE;
    logic        UpdateE, IsJumpE, TakenE, PredTakenE;
    logic        PredTakenF, MispredictE;
    logic [31:0] PredTargetF;
    logic [15:0] MispredCount;
    logic        PredTakenF2, MispredictE2;
    logic [31:0] PredTargetF2;
    logic [1:0]  MispredCount2;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
        .UpdateE(UpdateE), .IsJumpE(IsJumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
        .MispredCount(MispredCount)
    );

    branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF2), .PredTargetF(PredTargetF2),
        .UpdateE(UpdateE), .IsJumpE(IsJumpE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE2),
        .MispredCount(MispredCount2)
    );

    typedef struct {
        string       name;
        logic        ptf;
        logic [31:0] ptg;
        logic        mis;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: BTB as plain arrays, counters as integers 0..3.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    int unsigned m_tgt   [16];
    int          m_ctr   [16];
    int unsigned m_cnt, m_cnt2;

    function automatic int unsigned idx_of(input logic [31:0] pc);
        return (pc >> 2) % 16;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return pc >> 6;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
    endfunction

    task automatic step(input bit chk, input string nm, input bit r, input logic [31:0] pcf,
                        input bit upd, input bit jmp, input logic [31:0] pce, input bit tk,
                        input logic [31:0] tg, input bit pte, input logic [31:0] ptge);
        exp_t        e;
        bit          mis;
        int unsigned k;
        rst = r; PCF = pcf; UpdateE = upd; IsJumpE = jmp; PCE = pce;
        TakenE = tk; TargetE = tg; PredTakenE = pte; PredTargetE = ptge;
        mis = upd && ((pte != tk) || (tk && (ptge != tg)));
        if (chk) begin
            e.name = nm;
            e.ptf  = m_pred(pcf);
            e.ptg  = e.ptf ? m_tgt[idx_of(pcf)] : 32'd0;
            e.mis  = mis;
            e.cnt  = 16'(m_cnt);
            e.cnt2 = 2'(m_cnt2);
            sb.push_back(e);
        end
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
            end
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (upd) begin
            if (mis) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            k = idx_of(pce);
            if (m_hit(pce)) begin
                if (jmp) begin
                    m_ctr[k] = 3; m_tgt[k] = tg;
                end else if (tk) begin
                    if (m_ctr[k] < 3) m_ctr[k]++;
                    m_tgt[k] = tg;
                end else if (m_ctr[k] > 0) begin
                    m_ctr[k]--;
                end
            end else if (tk) begin
                m_valid[k] = 1'b1; m_tag[k] = tag_of(pce); m_tgt[k] = tg;
                m_ctr[k] = jmp ? 3 : 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc);
        step(1'b1, nm, 1'b0, pc, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic train(input string nm, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                         input bit jmp, input bit pte, input logic [31:0] ptge);
        step(1'b1, nm, 1'b0, pc, 1'b1, jmp, pc, tk, tg, pte, ptge);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "PredTakenF",   32'(PredTakenF),    32'(e.ptf));
            cmp(e.name, "PredTargetF",  PredTargetF,        e.ptg);
            cmp(e.name, "MispredictE",  32'(MispredictE),   32'(e.mis));
            cmp(e.name, "MispredCount", 32'(MispredCount),  32'(e.cnt));
            cmp(e.name, "MispredCount2", 32'(MispredCount2), 32'(e.cnt2));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc, tg, pf;
        bit          tk, jp, pte;
        rst = 1'b1; PCF = '0; PCE = '0; TargetE = '0; PredTargetE = '0;
        UpdateE = 1'b0; IsJumpE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
        @(posedge clk); #1;
        step(1'b0, "init_rst", 1'b1, 32'h100, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        // T1 reset
        step(1'b1, "t1_rst", 1'b1, 32'h100, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
        lookup("t1_lookup", 32'h100);
        // T2 allocate
        train("t2_alloc", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        lookup("t2_hit", 32'h100);
        // T3 hysteresis
        train("t3_nt1", 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        lookup("t3_weak", 32'h100);
        train("t3_tk1", 32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
        lookup("t3_back", 32'h100);
        train("t3_tk2", 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
        train("t3_tk3", 32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
        train("t3_nt2", 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        lookup("t3_still", 32'h100);
        // T4 aliasing
        lookup("t4_alias", 32'h140);
        train("t4_evict", 32'h140, 1'b1, 32'hC0, 1'b0, 1'b0, 32'h0);
        lookup("t4_old", 32'h100);
        lookup("t4_new", 32'h140);
        // T5 jump and target change
        train("t5_jump", 32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0);
        lookup("t5_hit", 32'h200);
        train("t5_retarget", 32'h200, 1'b1, 32'h340, 1'b1, 1'b1, 32'h300);
        lookup("t5_new", 32'h200);
        // same-cycle lookup/update at the same index: pre-update contents
        step(1'b1, "nobypass", 1'b0, 32'h180, 1'b1, 1'b0, 32'h180, 1'b1, 32'h44, 1'b0, 0);
        lookup("nobypass_after", 32'h180);
        // T6 saturation then reset with a concurrent update
        for (int i = 0; i < 5; i++)
            train("t6_mis", 32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
        lookup("t6_sat", 32'h500);
        step(1'b1, "t6_rst_upd", 1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h900, 1'b0, 0);
        lookup("t6_after_a", 32'h500);
        lookup("t6_after_b", 32'h200);
        // randomized traffic over a small PC space to force hits and aliasing
        for (int n = 0; n < 600; n++) begin
            pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            pf  = ($urandom_range(0, 2) == 0) ? pc :
                  (($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 2));
            tg  = 32'h1000 + ($urandom_range(0, 3) << 4);
            tk  = $urandom_range(0, 1) == 1;
            jp  = $urandom_range(0, 5) == 0;
            if (jp) tk = 1'b1;
            pte = ($urandom_range(0, 3) != 0) ? m_pred(pc) : bit'($urandom_range(0, 1));
            step(1'b1, "rand", $urandom_range(0, 60) == 0, pf, $urandom_range(0, 3) != 0, jp,
                 pc, tk, tg, pte, (pte && m_hit(pc)) ? m_tgt[idx_of(pc)] : tg);
        end
        rst = 1'b0; UpdateE = 1'b0;
        for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
